// File: rtl/ofdm_index_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : ofdm_index_sequencer_if
// Purpose : Control/status bundle between the symbol controller and the
//           OFDM index sequencer.
// Rev     : 1.0  initial release
// ============================================================================
interface ofdm_index_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int OUT_W  = 8,
  parameter int SYM_W  = 8
);
  logic              en;
  logic              start;
  logic              cont;
  logic [ADDR_W-1:0] cp_len;
  logic [OUT_W-1:0]  out_re;
  logic [OUT_W-1:0]  out_im;
  logic              valid;
  logic              cp_phase;
  logic              sym_last;
  logic              busy;
  logic [SYM_W-1:0]  sym_cnt;

  modport master (
    output en, start, cont, cp_len,
    input  out_re, out_im, valid, cp_phase, sym_last, busy, sym_cnt
  );

  modport slave (
    input  en, start, cont, cp_len,
    output out_re, out_im, valid, cp_phase, sym_last, busy, sym_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ofdm_index_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ofdm_index_sequencer
// Purpose : Per-symbol up/mirrored index generator with cyclic-prefix phase,
//           continuous-symbol handshake and symbol counter. Falling-edge
//           registers. Optional macro OFDM_IDX_BITREV_EN: bit-reversed DATA.
// Rev     : 1.0  initial release
// ============================================================================
module ofdm_index_sequencer #(
  parameter int ADDR_W = 6,
  parameter int OUT_W  = 8,
  parameter int SYM_W  = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  ofdm_index_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CP   = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] C_LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] C_ZERO_IDX = '0;
  localparam logic [ADDR_W-1:0] C_ONE_IDX  = ADDR_W'(1);
  localparam logic [SYM_W-1:0]  C_ONE_SYM  = SYM_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] cp_len_q, cp_len_d;
  logic [SYM_W-1:0]  sym_cnt_q, sym_cnt_d;

  logic [ADDR_W-1:0] w_cp_sel;
  state_e            w_first_state;
  logic [ADDR_W-1:0] w_first_idx;
  logic [ADDR_W-1:0] w_re_addr;
  logic [OUT_W-1:0]  w_out_re;
  logic [OUT_W-1:0]  w_out_im;

`ifdef OFDM_IDX_BITREV_EN
  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      r[b] = v[ADDR_W-1-b];
    end
    return r;
  endfunction
`endif

  // A new symbol starts from the live cp_len in IDLE and from the latched copy
  // on a continuous restart; N - cp_len wraps to 0 when cp_len is 0.
  assign w_cp_sel      = (state_q == S_IDLE) ? bus.cp_len : cp_len_q;
  assign w_first_state = (w_cp_sel != C_ZERO_IDX) ? S_CP : S_DATA;
  assign w_first_idx   = C_ZERO_IDX - w_cp_sel;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cp_len_q  <= '0;
      sym_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cp_len_q  <= cp_len_d;
      sym_cnt_q <= sym_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cp_len_d  = cp_len_q;
    sym_cnt_d = sym_cnt_q;
    if (bus.en) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            cp_len_d = bus.cp_len;
            state_d  = w_first_state;
            idx_d    = w_first_idx;
          end
        end
        S_CP: begin
          if (idx_q == C_LAST_IDX) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + C_ONE_IDX;
          end
        end
        S_DATA: begin
          if (idx_q == C_LAST_IDX) begin
            sym_cnt_d = sym_cnt_q + C_ONE_SYM;
            if (bus.cont) begin
              state_d = w_first_state;
              idx_d   = w_first_idx;
            end else begin
              state_d = S_IDLE;
              idx_d   = '0;
            end
          end else begin
            idx_d = idx_q + C_ONE_IDX;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_re_addr = idx_q;
`ifdef OFDM_IDX_BITREV_EN
    if (state_q == S_DATA) begin
      w_re_addr = bitrev(idx_q);
    end
`endif
    w_out_re                = '0;
    w_out_im                = '0;
    w_out_re[ADDR_W-1:0]    = w_re_addr;
    // N-1-x over ADDR_W bits is the one's complement of x.
    w_out_im[ADDR_W-1:0]    = ~w_re_addr;
  end

  assign bus.out_re   = w_out_re;
  assign bus.out_im   = w_out_im;
  assign bus.valid    = (state_q != S_IDLE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.cp_phase = (state_q == S_CP);
  assign bus.sym_last = (state_q == S_DATA) && (idx_q == C_LAST_IDX);
  assign bus.sym_cnt  = sym_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ofdm_index_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ofdm_index_sequencer
// Purpose : Scoreboard bench for ofdm_index_sequencer (N=64, 8-bit outputs).
// Rev     : 1.0  initial release
// ============================================================================
module tb_ofdm_index_sequencer;

  typedef struct packed {
    logic [7:0] re;
    logic [7:0] im;
    logic       cp;
    logic       last;
    logic [7:0] sc;
  } exp_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  bit   mon_on;
  exp_t exp_q[$];

  ofdm_index_sequencer_if #(.ADDR_W(6), .OUT_W(8), .SYM_W(8)) bus ();

  ofdm_index_sequencer #(.ADDR_W(6), .OUT_W(8), .SYM_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int brev6(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) begin
      if (((k >> b) & 1) != 0) r = r | (1 << (5 - b));
    end
    return r;
  endfunction

  task automatic push1(input int re, input int im, input logic cp, input logic last, input int sc);
    exp_t e;
    e.re   = 8'(re);
    e.im   = 8'(im);
    e.cp   = cp;
    e.last = last;
    e.sc   = 8'(sc);
    exp_q.push_back(e);
  endtask

  task automatic push_data(input int k, input int sc);
    int r;
`ifdef OFDM_IDX_BITREV_EN
    r = brev6(k);
`else
    r = k;
`endif
    push1(r, 63 - r, 1'b0, (k == 63), sc);
  endtask

  task automatic push_sym(input int cpl, input int sc);
    for (int i = 64 - cpl; i < 64; i++) push1(i, 63 - i, 1'b1, 1'b0, sc);
    for (int k = 0; k < 64; k++) push_data(k, sc);
  endtask

  task automatic cyc(input logic e, input logic s, input logic c, input logic [5:0] cl);
    @(posedge clk);
    bus.en     = e;
    bus.start  = s;
    bus.cont   = c;
    bus.cp_len = cl;
  endtask

  task automatic check_sc(input string name, input int req);
    n_vec++;
    if (bus.sym_cnt !== 8'(req)) begin
      n_err++;
      $display("FAIL %s: sym_cnt=%0d required %0d", name, bus.sym_cnt, req);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every live index must match the head of the scoreboard; idle
  // cycles must show the IDLE output values.
  always @(posedge clk) begin
    exp_t e;
    if (mon_on) begin
      n_vec++;
      if (bus.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid: re=%0d im=%0d, required no valid output",
                   bus.out_re, bus.out_im);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_re, bus.out_im, bus.cp_phase, bus.sym_last, bus.sym_cnt, bus.busy}
              !== {e.re, e.im, e.cp, e.last, e.sc, 1'b1}) begin
            n_err++;
            $display("FAIL seq @%0t: re=%0d im=%0d cp=%0b last=%0b sc=%0d busy=%0b required re=%0d im=%0d cp=%0b last=%0b sc=%0d busy=1",
                     $time, bus.out_re, bus.out_im, bus.cp_phase, bus.sym_last, bus.sym_cnt,
                     bus.busy, e.re, e.im, e.cp, e.last, e.sc);
          end
        end
      end else if ({bus.valid, bus.out_re, bus.out_im, bus.cp_phase, bus.sym_last, bus.busy}
                   !== {1'b0, 8'd0, 8'd63, 1'b0, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL idle @%0t: valid=%0b re=%0d im=%0d cp=%0b last=%0b busy=%0b required 0/0/63/0/0/0",
                 $time, bus.valid, bus.out_re, bus.out_im, bus.cp_phase, bus.sym_last, bus.busy);
      end
    end
  end

  initial begin
    n_vec      = 0;
    n_err      = 0;
    mon_on     = 1'b0;
    reset      = 1'b0;
    bus.en     = 1'b0;
    bus.start  = 1'b0;
    bus.cont   = 1'b0;
    bus.cp_len = '0;
    #1 mon_on = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b1;

    // Idle after reset release
    repeat (10) cyc(1'b1, 1'b0, 1'b0, 6'd0);
    check_sc("reset_sym_cnt", 0);

    // cp_len=16 single symbol; a busy start with a new cp_len is ignored
    push_sym(16, 0);
    cyc(1'b1, 1'b1, 1'b0, 6'd16);
    repeat (19) cyc(1'b1, 1'b0, 1'b0, 6'd16);
    cyc(1'b1, 1'b1, 1'b0, 6'd5);
    repeat (80) cyc(1'b1, 1'b0, 1'b0, 6'd5);
    check_sc("cp16_sym_cnt", 1);

    // Three back-to-back symbols without prefix
    do_reset();
    check_sc("reset2_sym_cnt", 0);
    push_sym(0, 0);
    push_sym(0, 1);
    push_sym(0, 2);
    cyc(1'b1, 1'b1, 1'b1, 6'd0);
    repeat (190) cyc(1'b1, 1'b0, 1'b1, 6'd0);
    cyc(1'b1, 1'b0, 1'b0, 6'd0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 6'd0);
    check_sc("cont3_sym_cnt", 3);

    // Continuous restart through a 1-sample prefix using the latched cp_len
    push_sym(1, 3);
    push_sym(1, 4);
    cyc(1'b1, 1'b1, 1'b1, 6'd1);
    repeat (128) cyc(1'b1, 1'b0, 1'b1, 6'd0);
    cyc(1'b1, 1'b0, 1'b0, 6'd0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 6'd0);
    check_sc("cont_cp1_sym_cnt", 5);

    // Stall for 5 edges at data index 30
    for (int k = 0; k <= 30; k++) push_data(k, 5);
    repeat (5) push_data(30, 5);
    for (int k = 31; k < 64; k++) push_data(k, 5);
    cyc(1'b1, 1'b1, 1'b0, 6'd0);
    repeat (30) cyc(1'b1, 1'b0, 1'b0, 6'd0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 6'd0);
    repeat (40) cyc(1'b1, 1'b0, 1'b0, 6'd0);
    check_sc("stall_sym_cnt", 6);

    // Reset mid-prefix at index 50 with cp_len=20
    for (int i = 44; i <= 50; i++) push1(i, 63 - i, 1'b1, 1'b0, 6);
    cyc(1'b1, 1'b1, 1'b0, 6'd20);
    repeat (6) cyc(1'b1, 1'b0, 1'b0, 6'd20);
    @(posedge clk);
    #2;
    check_sc("pre_reset_sym_cnt", 6);
    reset = 1'b0;
    #1;
    n_vec++;
    if ({bus.valid, bus.out_re, bus.out_im, bus.busy, bus.sym_cnt}
        !== {1'b0, 8'd0, 8'd63, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL async_reset: valid=%0b re=%0d im=%0d busy=%0b sc=%0d required 0/0/63/0/0",
               bus.valid, bus.out_re, bus.out_im, bus.busy, bus.sym_cnt);
    end
    @(posedge clk);
    reset = 1'b1;
    push_sym(20, 0);
    cyc(1'b1, 1'b1, 1'b0, 6'd20);
    repeat (90) cyc(1'b1, 1'b0, 1'b0, 6'd0);
    check_sc("post_reset_sym_cnt", 1);

    repeat (5) cyc(1'b1, 1'b0, 1'b0, 6'd0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected indices never appeared, required 0", exp_q.size());
    end
    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
